// File: rtl/spi_master_rw.sv
// SPI master: accepts one command word per frame and runs write or read frames
// in any CPOL/CPHA mode with a programmable SCLK divider and several chip selects.
module spi_master_rw #(
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int NUM_CS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CMD_WIDTH-1:0]          cmd_in,
    input  logic [$clog2(NUM_CS):0]       cs_sel,
    input  logic                          cmd_vld,
    output logic                          cmd_rdy,
    output logic                          busy,
    output logic                          sclk,
    output logic [NUM_CS-1:0]             cs_n,
    output logic                          mosi,
    input  logic                          miso,
    output logic                          read_vld,
    output logic [READ_WIDTH-1:0]         read_data
);

    localparam int SEL_W  = $clog2(NUM_CS) + 1;
    localparam int EDGE_W = $clog2(2 * CMD_WIDTH) + 1;
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * CMD_WIDTH - 1);
    localparam logic              SCLK_IDLE = (CPOL != 0);
    localparam logic              PHA       = (CPHA != 0);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [EDGE_W-1:0]       edge_cnt;
    logic [CMD_WIDTH-1:0]    shreg;
    logic [READ_WIDTH-1:0]   capture;
    logic                    is_read;
    logic [NUM_CS-1:0]       cs_decode;
    logic [CMD_WIDTH-1:0]    load_word;
    logic                    div_done;
    logic                    sample_edge;

    // Read frames send only the header; the data phase drives zeros on mosi.
    assign load_word = cmd_in[CMD_WIDTH-1] ? cmd_in
                     : {cmd_in[CMD_WIDTH-1:READ_WIDTH], {READ_WIDTH{1'b0}}};

    assign div_done    = (div_cnt == DIV_LAST);
    // Even edge_cnt means the next toggle is a leading edge.
    assign sample_edge = (edge_cnt[0] == PHA);

    // An out-of-range select leaves every chip select deasserted.
    always_comb begin
        cs_decode = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == SEL_W'(i)) begin
                cs_decode[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            shreg     <= '0;
            capture   <= '0;
            is_read   <= 1'b0;
            sclk      <= SCLK_IDLE;
            cs_n      <= '1;
            mosi      <= 1'b0;
            cmd_rdy   <= 1'b1;
            busy      <= 1'b0;
            read_vld  <= 1'b0;
            read_data <= '0;
        end else begin
            read_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_vld && cmd_rdy) begin
                        state    <= LEAD;
                        cmd_rdy  <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        cs_n     <= cs_decode;
                        is_read  <= ~cmd_in[CMD_WIDTH-1];
                        // With CPHA=0 the first bit must be valid before the first edge.
                        if (!PHA) begin
                            mosi  <= load_word[CMD_WIDTH-1];
                            shreg <= load_word << 1;
                        end else begin
                            shreg <= load_word;
                        end
                    end
                end
                LEAD: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            capture <= (capture << 1) | READ_WIDTH'(miso);
                        end else begin
                            mosi  <= shreg[CMD_WIDTH-1];
                            shreg <= shreg << 1;
                        end
                        if (edge_cnt == EDGE_LAST) begin
                            state <= TRAIL;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= GAP;
                        cs_n    <= '1;
                        if (is_read) begin
                            read_vld  <= 1'b1;
                            read_data <= capture;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        cmd_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_rw.sv
// Bench for spi_master_rw: a mode-0 two-CS instance and a mode-3 single-CS instance,
// checked against a scoreboard of expected frames and an SPI slave model.
module tb_spi_master_rw;

    typedef struct packed {
        logic [11:0] mosi_word;
        logic        is_read;
        logic [7:0]  rdata;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [11:0] cmd_a = '0;
    logic [1:0]  sel_a = '0;
    logic        vld_a = 1'b0;
    logic        rdy_a, busy_a, sclk_a, mosi_a, rvld_a;
    logic        miso_a = 1'b0;
    logic [1:0]  cs_a;
    logic [7:0]  rdata_a;

    logic [11:0] cmd_b = '0;
    logic [0:0]  sel_b = '0;
    logic        vld_b = 1'b0;
    logic        rdy_b, busy_b, sclk_b, mosi_b, rvld_b;
    logic        miso_b = 1'b0;
    logic [0:0]  cs_b;
    logic [7:0]  rdata_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit check_gap = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    spi_master_rw #(.CMD_WIDTH(12), .READ_WIDTH(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .NUM_CS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_a), .cs_sel(sel_a), .cmd_vld(vld_a),
        .cmd_rdy(rdy_a), .busy(busy_a), .sclk(sclk_a), .cs_n(cs_a), .mosi(mosi_a),
        .miso(miso_a), .read_vld(rvld_a), .read_data(rdata_a)
    );

    spi_master_rw #(.CMD_WIDTH(12), .READ_WIDTH(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .NUM_CS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_b), .cs_sel(sel_b), .cmd_vld(vld_b),
        .cmd_rdy(rdy_b), .busy(busy_b), .sclk(sclk_b), .cs_n(cs_b), .mosi(mosi_b),
        .miso(miso_b), .read_vld(rvld_b), .read_data(rdata_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the command was accepted.
    task automatic applyStimulus(input int dut, input logic [11:0] cmd, input logic [1:0] sel,
                                 input logic [7:0] rdata, input bit keep);
        exp_t e;
        int n;
        e.mosi_word = cmd[11] ? cmd : {cmd[11:8], 8'h00};
        e.is_read   = ~cmd[11];
        e.rdata     = rdata;
        e.sel       = sel;
        if (dut == 0) begin
            cmd_a = cmd; sel_a = sel; vld_a = 1'b1; q_a.push_back(e);
        end else begin
            cmd_b = cmd; sel_b = sel[0]; vld_b = 1'b1; q_b.push_back(e);
        end
        n = 0;
        while (!((dut == 0) ? rdy_a : rdy_b) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_timeout", (n < 500), 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rdy_drop", (dut == 0) ? rdy_a : rdy_b, 0);
        checkOutput("busy_set", (dut == 0) ? busy_a : busy_b, 1);
        if (!keep) begin
            if (dut == 0) vld_a = 1'b0;
            else vld_b = 1'b0;
        end
    endtask

    task automatic waitIdle(input int dut);
        int n = 0;
        while (n < 1000 && !((dut == 0) ? (q_a.size() == 0 && rdy_a) : (q_b.size() == 0 && rdy_b))) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", (n < 1000), 1);
        @(negedge clk);
    endtask

    // Monitor and slave model for instance A (mode 0): slave samples on rising sclk.
    logic [11:0] bits_a, slave_a;
    int          nb_a, busy_cyc_a, c0_a, c1_a, rv_a, viol_a = 0, cs0_high = 0, last_start_a = 0;
    logic [7:0]  rd_a;
    logic [1:0]  fr_sel_a, pcs_a = 2'b11;
    bit          in_fr_a = 0, rv_ok_a, gap_armed = 0;
    logic        psclk_a = 1'b0, pmosi_a = 1'b0, pbusy_a = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            in_fr_a = 0; psclk_a = 1'b0; pmosi_a = 1'b0; pbusy_a = 1'b0; pcs_a = 2'b11;
            gap_armed = 0; miso_a = 1'b0;
        end else begin
            if (busy_a && !pbusy_a) begin
                in_fr_a = 1; bits_a = '0; nb_a = 0; busy_cyc_a = 0; c0_a = 0; c1_a = 0;
                rv_a = 0; rv_ok_a = 0; rd_a = '0;
                if (q_a.size() > 0) begin
                    fr_sel_a = q_a[0].sel;
                    slave_a  = {4'($urandom), q_a[0].rdata};
                end else begin
                    fr_sel_a = 2'd0;
                    slave_a  = '0;
                end
                miso_a = slave_a[11];
                if (check_gap) begin
                    if (gap_armed) checkOutput("A_accept_spacing", cyc - last_start_a, 55);
                    gap_armed = 1;
                end
                last_start_a = cyc;
            end
            if (!check_gap) gap_armed = 0;
            if (mosi_a != pmosi_a && !(psclk_a && !sclk_a) && !(busy_a && !pbusy_a)) viol_a++;
            if (!cs_a[0] && pcs_a[0] && check_gap) checkOutput("A_cs_high_gap", (cs0_high >= 2), 1);
            cs0_high = cs_a[0] ? cs0_high + 1 : 0;
            if (in_fr_a) begin
                if (busy_a) busy_cyc_a++;
                if (sclk_a && !psclk_a) begin
                    bits_a = {bits_a[10:0], mosi_a};
                    nb_a++;
                end
                if (!sclk_a && psclk_a) begin
                    slave_a = slave_a << 1;
                    miso_a  = slave_a[11];
                end
                c0_a += int'(!cs_a[0]);
                c1_a += int'(!cs_a[1]);
                if (rvld_a) begin
                    rv_a++;
                    rd_a = rdata_a;
                    rv_ok_a = (cs_a == 2'b11) && (pcs_a != 2'b11 || fr_sel_a >= 2);
                end
                if (!busy_a) begin
                    in_fr_a = 0;
                    if (q_a.size() == 0) begin
                        checkOutput("A_unexpected_frame", 1, 0);
                    end else begin
                        e = q_a.pop_front();
                        checkOutput("A_mosi_word", bits_a, e.mosi_word);
                        checkOutput("A_nbits", nb_a, 12);
                        checkOutput("A_busy_cycles", busy_cyc_a, 54);
                        checkOutput("A_cs0_low", c0_a, (e.sel == 0) ? 52 : 0);
                        checkOutput("A_cs1_low", c1_a, (e.sel == 1) ? 52 : 0);
                        checkOutput("A_read_vld_count", rv_a, e.is_read);
                        checkOutput("A_mosi_change_edges", viol_a, 0);
                        checkOutput("A_sclk_idle", sclk_a, 0);
                        if (e.is_read) begin
                            checkOutput("A_read_data", rd_a, e.rdata);
                            checkOutput("A_read_vld_at_cs_rise", rv_ok_a, 1);
                        end
                    end
                end
            end
            psclk_a = sclk_a; pmosi_a = mosi_a; pbusy_a = busy_a; pcs_a = cs_a;
        end
    end

    // Monitor for instance B (mode 3): slave samples on rising sclk, mosi may move only on falling.
    logic [11:0] bits_b;
    int          nb_b, c_b, rv_b, viol_b = 0;
    bit          in_fr_b = 0;
    logic        psclk_b = 1'b1, pmosi_b = 1'b0, pbusy_b = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_fr_b = 0; psclk_b = 1'b1; pmosi_b = 1'b0; pbusy_b = 1'b0;
        end else begin
            if (busy_b && !pbusy_b) begin
                in_fr_b = 1; bits_b = '0; nb_b = 0; c_b = 0; rv_b = 0;
            end
            if (mosi_b != pmosi_b && !(psclk_b && !sclk_b)) viol_b++;
            if (in_fr_b) begin
                if (sclk_b && !psclk_b) begin
                    bits_b = {bits_b[10:0], mosi_b};
                    nb_b++;
                end
                c_b += int'(!cs_b[0]);
                rv_b += int'(rvld_b);
                if (!busy_b) begin
                    in_fr_b = 0;
                    if (q_b.size() == 0) begin
                        checkOutput("B_unexpected_frame", 1, 0);
                    end else begin
                        e = q_b.pop_front();
                        checkOutput("B_mosi_word", bits_b, e.mosi_word);
                        checkOutput("B_nbits", nb_b, 12);
                        checkOutput("B_cs_low", c_b, 52);
                        checkOutput("B_read_vld_count", rv_b, e.is_read);
                        checkOutput("B_sclk_idle", sclk_b, 1);
                        checkOutput("B_mosi_change_edges", viol_b, 0);
                    end
                end
            end
            psclk_b = sclk_b; pmosi_b = mosi_b; pbusy_b = busy_b;
        end
    end

    initial begin
        logic [11:0] rcmd;
        logic [7:0]  rdat;
        logic        ps;
        int          ec, n;

        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", cs_a, 2'b11);
        checkOutput("rst_sclk", sclk_a, 0);
        checkOutput("rst_mosi", mosi_a, 0);
        checkOutput("rst_cmd_rdy", rdy_a, 1);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_read_vld", rvld_a, 0);
        checkOutput("rst_read_data", rdata_a, 0);
        checkOutput("rst_b_sclk", sclk_b, 1);
        checkOutput("rst_b_cs_n", cs_b, 1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] write A5C on cs0");
        applyStimulus(0, 12'hA5C, 2'd0, 8'h00, 0);
        waitIdle(0);

        $display("[TB] read 35A returning C3, then random reads");
        applyStimulus(0, 12'h35A, 2'd0, 8'hC3, 0);
        waitIdle(0);
        for (int i = 0; i < 3; i++) begin
            rcmd = 12'($urandom) & 12'h7FF;
            rdat = 8'($urandom);
            applyStimulus(0, rcmd, 2'($urandom_range(0, 1)), rdat, 0);
            waitIdle(0);
        end

        $display("[TB] back-to-back commands with cmd_vld held");
        check_gap = 1;
        applyStimulus(0, 12'hF0F, 2'd0, 8'h00, 1);
        applyStimulus(0, 12'h123, 2'd0, 8'h5A, 0);
        waitIdle(0);
        check_gap = 0;

        $display("[TB] mode 3 write A5C");
        applyStimulus(1, 12'hA5C, 2'd0, 8'h00, 0);
        waitIdle(1);

        $display("[TB] chip select 1 and out-of-range select");
        applyStimulus(0, 12'h9C3, 2'd1, 8'h00, 0);
        waitIdle(0);
        applyStimulus(0, 12'h2AB, 2'd2, 8'h69, 0);
        waitIdle(0);

        $display("[TB] reset during a read");
        applyStimulus(0, 12'h4E1, 2'd0, 8'hAA, 0);
        ec = 0;
        n = 0;
        ps = sclk_a;
        while (ec < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (sclk_a != ps) ec++;
            ps = sclk_a;
        end
        checkOutput("edge_wait_timeout", (n < 400), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_cs_n", cs_a, 2'b11);
        checkOutput("abort_sclk", sclk_a, 0);
        checkOutput("abort_read_vld", rvld_a, 0);
        checkOutput("abort_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        q_a.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_cmd_rdy", rdy_a, 1);
        checkOutput("post_rst_read_data", rdata_a, 0);
        applyStimulus(0, 12'hB7E, 2'd0, 8'h00, 0);
        waitIdle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
